// File: rtl/ksa_stream_accum_pkg.sv
// Shared definitions for the Kogge-Stone streaming accumulator.
//   state_e     : FSM encoding (IDLE=0, ACCUM=1, HOLD=2)
//   DefWidth    : default operand width
//   DefMaxOps   : default maximum operands per burst
//   DefAccW     : default accumulator width for the defaults above
//   clamp_ops() : limits a requested burst length to the configured maximum
package ksa_stream_accum_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefMaxOps = 16;
  localparam int unsigned DefAccW   = DefWidth + $clog2(DefMaxOps);

  function automatic logic [4:0] clamp_ops(input logic [4:0] n, input int unsigned max_ops);
    return (32'(n) > max_ops) ? 5'(max_ops) : n;
  endfunction

endpackage

// File: rtl/ksa_stream_accum_core.sv
// Combinational N-bit Kogge-Stone adder.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, low N bits
//   cout : carry out of bit N-1
// Bitwise generate/propagate, $clog2(N) prefix levels of span 1,2,4,...,
// then the carry-in is folded in using the full-span group terms.
module ksa_stream_accum_core
  import ksa_stream_accum_pkg::*;
#(
  parameter int unsigned N = DefAccW
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned Levels = $clog2(N);

  // g[s][i] / p[s][i]: group generate/propagate of bits i down to i-2^s+1
  logic [N-1:0] g [Levels+1];
  logic [N-1:0] p [Levels+1];
  logic [N:0]   carry;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar s = 0; s < Levels; s++) begin : g_stage
    localparam int Dist = 1 << s;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= Dist) begin : g_merge
        assign g[s+1][i] = g[s][i] | (p[s][i] & g[s][i-Dist]);
        assign p[s+1][i] = p[s][i] & p[s][i-Dist];
      end else begin : g_pass
        assign g[s+1][i] = g[s][i];
        assign p[s+1][i] = p[s][i];
      end
    end
  end

  // After the last level each group spans bit i down to bit 0, so the carry
  // into bit i+1 is that group's generate, or its propagate of cin.
  assign carry[0]   = cin;
  assign carry[N:1] = g[Levels] | (p[Levels] & {N{cin}});

  assign sum  = p[0] ^ carry[N-1:0];
  assign cout = carry[N];

endmodule

// File: rtl/ksa_stream_accum.sv
// Streaming multi-operand accumulator around a Kogge-Stone adder.
//   clk, rst  : clock and synchronous active-high reset
//   start     : begin a burst (sampled only when idle)
//   num_ops   : burst length, sampled with start, clamped to MAX_OPS
//   in_valid  : operand valid           in_ready  : operand accepted
//   in_data   : operand (zero-extended to the accumulator width)
//   out_valid : result valid            out_ready : result consumed
//   out_sum   : accumulated sum         busy      : not idle
// All outputs are registered; no input reaches an output combinationally.
module ksa_stream_accum
  import ksa_stream_accum_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned MAX_OPS = DefMaxOps,
  localparam int unsigned ACC_W  = WIDTH + $clog2(MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       num_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(MAX_OPS + 1);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  n_q;

  logic [4:0]       n_clamped;
  logic [CntW-1:0]  count_inc;
  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic [ACC_W-1:0] acc_next;
  logic             in_hs;

  assign n_clamped = clamp_ops(num_ops, MAX_OPS);
  assign count_inc = count_q + CntW'(1);
  assign in_hs     = in_valid & in_ready;

  ksa_stream_accum_core #(
    .N (ACC_W)
  ) u_ksa (
    .a    (acc_q),
    .b    (ACC_W'(in_data)),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // ACC_W is sized so a legal burst cannot carry out; saturate rather than
  // wrap should the parameters ever be overridden inconsistently.
  assign acc_next = add_cout ? {ACC_W{1'b1}} : add_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      count_q   <= '0;
      n_q       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q   <= '0;
            count_q <= '0;
            n_q     <= CntW'(n_clamped);
            busy    <= 1'b1;
            if (n_clamped == 5'd0) begin
              state_q   <= StHold;
              out_sum   <= '0;
              out_valid <= 1'b1;
            end else begin
              state_q  <= StAccum;
              in_ready <= 1'b1;
            end
          end
        end

        StAccum: begin
          if (in_hs) begin
            acc_q   <= acc_next;
            count_q <= count_inc;
            if (count_inc == n_q) begin
              state_q   <= StHold;
              in_ready  <= 1'b0;
              out_sum   <= acc_next;
              out_valid <= 1'b1;
            end
          end
        end

        StHold: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_stream_accum.sv
// Directed bench for ksa_stream_accum: a table of bursts with hand-computed
// sums, hand-written hold/abort sequences, and an exhaustive 8-bit check of
// the Kogge-Stone core on its own.
module tb_ksa_stream_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  num_ops;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        busy;

  logic [7:0]  ca, cb;
  logic        ccin;
  logic [7:0]  csum;
  logic        ccout;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ksa_stream_accum #(
    .WIDTH   (8),
    .MAX_OPS (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  ksa_stream_accum_core #(
    .N (8)
  ) u_core (
    .a    (ca),
    .b    (cb),
    .cin  (ccin),
    .sum  (csum),
    .cout (ccout)
  );

  typedef struct packed {
    logic [4:0]       nops;
    logic             gap;
    logic [4:0]       nsup;
    logic [19:0][7:0] data;
    logic [11:0]      exp_sum;
    logic [4:0]       exp_acc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: data[0]=a, data[1]=b; mode 1: every entry a; mode 2: ramp 1..20
  function automatic vec_t mk(input logic [4:0] nops, input logic gap, input logic [4:0] nsup,
                              input int mode, input logic [7:0] a, input logic [7:0] b,
                              input logic [11:0] exp_sum, input logic [4:0] exp_acc);
    vec_t v;
    v.nops = nops;
    v.gap  = gap;
    v.nsup = nsup;
    v.data = '0;
    for (int i = 0; i < 20; i++) begin
      if (mode == 1) v.data[i] = a;
      else if (mode == 2) v.data[i] = 8'(i + 1);
    end
    if (mode == 0) begin
      v.data[0] = a;
      v.data[1] = b;
    end
    v.exp_sum = exp_sum;
    v.exp_acc = exp_acc;
    return v;
  endfunction

  // Runs one complete burst including the output handshake.
  task automatic run_burst(input vec_t v, input string tag);
    int accepts = 0;
    int idx = 0;
    int cyc = 0;
    int last_acc = -1;
    bit saw_ready = 1'b0;
    start   = 1'b1;
    num_ops = v.nops;
    tick();
    start = 1'b0;
    while (!out_valid && cyc < 200) begin
      in_valid = (!v.gap || (cyc % 2 == 0)) && (idx < int'(v.nsup));
      in_data  = v.data[idx];
      if (in_ready) saw_ready = 1'b1;
      if (in_valid && in_ready) begin
        accepts++;
        idx++;
        last_acc = cyc;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_sum"}, 32'(out_sum), 32'(v.exp_sum));
    chk({tag, " accepts"}, 32'(accepts), 32'(v.exp_acc));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " in_ready in hold"}, 32'(in_ready), 32'd0);
    if (v.exp_acc != 0) chk({tag, " latency"}, 32'(cyc - last_acc), 32'd1);
    else chk({tag, " in_ready seen"}, 32'(saw_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid after"}, 32'(out_valid), 32'd0);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_ops   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ca = '0; cb = '0; ccin = 1'b0;

    vecs[0] = mk(5'd2,  1'b0, 5'd2,  0, 8'hA8, 8'h75, 12'h11D, 5'd2);
    vecs[1] = mk(5'd2,  1'b0, 5'd2,  0, 8'hB9, 8'hF7, 12'h1B0, 5'd2);
    vecs[2] = mk(5'd16, 1'b1, 5'd16, 1, 8'hFF, 8'h00, 12'hFF0, 5'd16);
    vecs[3] = mk(5'd0,  1'b0, 5'd4,  1, 8'h55, 8'h00, 12'h000, 5'd0);
    vecs[4] = mk(5'd20, 1'b0, 5'd20, 2, 8'h00, 8'h00, 12'h088, 5'd16);
    vecs[5] = mk(5'd31, 1'b1, 5'd20, 1, 8'hFF, 8'h00, 12'hFF0, 5'd16);
    vecs[6] = mk(5'd3,  1'b1, 5'd3,  2, 8'h00, 8'h00, 12'h006, 5'd3);
    vecs[7] = mk(5'd1,  1'b0, 5'd1,  0, 8'h00, 8'h00, 12'h000, 5'd1);
    vecs[8] = mk(5'd1,  1'b0, 5'd1,  0, 8'hFF, 8'h00, 12'h0FF, 5'd1);

    // Exhaustive core check while the accumulator sits in reset.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        for (int c = 0; c < 2; c++) begin
          ca = 8'(a); cb = 8'(b); ccin = 1'(c);
          #1;
          chk("core a+b+cin", 32'({ccout, csum}), 32'(a + b + c));
        end
      end
    end

    tick();
    tick();
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_sum", 32'(out_sum), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    tick();

    for (int i = 0; i < 9; i++) begin
      run_burst(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Result held under back-pressure; start pulses must be ignored.
    run_burst_hold();

    // Abort after 3 of 5 operands, then a clean burst must carry no residue.
    start   = 1'b1;
    num_ops = 5'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 * 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("abort in_ready", 32'(in_ready), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort out_sum", 32'(out_sum), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    run_burst(mk(5'd2, 1'b0, 5'd2, 0, 8'h80, 8'hC4, 12'h144, 5'd2), "post-abort");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  task automatic run_burst_hold();
    int cyc = 0;
    start   = 1'b1;
    num_ops = 5'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    in_data  = 8'h02;
    tick();
    in_valid = 1'b0;
    chk("hold out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      start    = (i % 2 == 0);
      num_ops  = 5'd2;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      tick();
      chk($sformatf("hold%0d out_sum", i), 32'(out_sum), 32'h003);
      chk($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold release out_valid", 32'(out_valid), 32'd0);
    chk("hold release busy", 32'(busy), 32'd0);
    // Wait a bounded time to confirm no burst was launched by the ignored starts.
    while (cyc < 3) begin
      tick();
      cyc++;
    end
    chk("hold no relaunch", 32'({busy, in_ready}), 32'd0);
  endtask

endmodule
